// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache-domain CPU responder: FSM states,
// default geometry and the byte-lane merge used on write hits and fills.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_RESP
  } state_e;

  localparam int DEF_ADDR_SIZE  = 16;
  localparam int DEF_WORD_SIZE  = 32;
  localparam int DEF_INDEX_BITS = 6;
  localparam int DEF_TAG_BITS   = DEF_ADDR_SIZE - DEF_INDEX_BITS;

  localparam logic [3:0] BVAL_ALL = 4'hF;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  bval);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (bval[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Direct-mapped line storage: valid bits with synchronous clear, plus tag and
// data arrays that are never reset. One shared index for lookup and update.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int TAG_BITS   = DEF_TAG_BITS,
  parameter int WORD_SIZE  = DEF_WORD_SIZE
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [INDEX_BITS-1:0] index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [WORD_SIZE-1:0]  rd_data,
  input  logic                  wr_en,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [WORD_SIZE-1:0]  wr_data,
  input  logic [3:0]            wr_bval
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     valid_d;
  logic [TAG_BITS-1:0]  tag_mem  [LINES];
  logic [WORD_SIZE-1:0] data_mem [LINES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[index] = 1'b1;
  end

  // Clear wins over a same-cycle write so reset always leaves the cache empty.
  always_ff @(posedge clk) begin
    if (clr) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[index]  <= wr_tag;
      data_mem[index] <= byte_merge(data_mem[index], wr_data, wr_bval);
    end
  end

  assign rd_valid = valid_q[index];
  assign rd_tag   = tag_mem[index];
  assign rd_data  = data_mem[index];

endmodule

// File: rtl/cache_cpu_responder.sv
// Services one-cycle CPU strobes from a direct-mapped, write-through,
// no-write-allocate cache, going to the memory port on misses and all writes.
module cache_cpu_responder
  import cache_pkg::*;
#(
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int INDEX_BITS = DEF_INDEX_BITS
) (
  input  logic                 cache_clk,
  input  logic                 cache_rst,
  input  logic [ADDR_SIZE-1:0] cache_addr,
  input  logic [WORD_SIZE-1:0] cache_wdata,
  input  logic [3:0]           cache_bval,
  input  logic                 cache_rd,
  input  logic                 cache_wr,
  output logic                 cache_ack,
  output logic [WORD_SIZE-1:0] cache_rdata,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic [3:0]           mem_bval,
  output logic                 mem_rd,
  output logic                 mem_wr,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 req_overrun
);

  localparam int TAG_BITS = ADDR_SIZE - INDEX_BITS;

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [3:0]           bval_q, bval_d;
  logic                 is_wr_q, is_wr_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 ack_q, ack_d;
  logic                 mem_rd_q, mem_rd_d;
  logic                 mem_wr_q, mem_wr_d;
  logic [3:0]           mem_bval_q, mem_bval_d;
  logic                 overrun_q, overrun_d;

  logic                 line_valid;
  logic [TAG_BITS-1:0]  line_tag;
  logic [WORD_SIZE-1:0] line_data;
  logic                 hit;
  logic                 strobe;
  logic                 st_wr_en;
  logic [WORD_SIZE-1:0] st_wr_data;
  logic [3:0]           st_wr_bval;

  cache_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .WORD_SIZE  (WORD_SIZE)
  ) u_store (
    .clk      (cache_clk),
    .clr      (cache_rst),
    .index    (addr_q[INDEX_BITS-1:0]),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (st_wr_en),
    .wr_tag   (addr_q[ADDR_SIZE-1:INDEX_BITS]),
    .wr_data  (st_wr_data),
    .wr_bval  (st_wr_bval)
  );

  assign hit    = line_valid && (line_tag == addr_q[ADDR_SIZE-1:INDEX_BITS]);
  assign strobe = cache_rd || cache_wr;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    bval_d     = bval_q;
    is_wr_d    = is_wr_q;
    rdata_d    = rdata_q;
    ack_d      = 1'b0;
    mem_rd_d   = mem_rd_q;
    mem_wr_d   = mem_wr_q;
    mem_bval_d = mem_bval_q;
    overrun_d  = overrun_q;
    st_wr_en   = 1'b0;
    st_wr_data = wdata_q;
    st_wr_bval = bval_q;

    case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          addr_d  = cache_addr;
          wdata_d = cache_wdata;
          bval_d  = cache_bval;
          is_wr_d = cache_wr;
          state_d = ST_LOOKUP;
          if (cache_rd && cache_wr) overrun_d = 1'b1;
        end
      end
      ST_LOOKUP: begin
        if (!is_wr_q) begin
          if (hit) begin
            rdata_d = line_data;
            ack_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            mem_rd_d   = 1'b1;
            mem_bval_d = BVAL_ALL;
            state_d    = ST_MEM_RD;
          end
        end else begin
          // Write-through: the memory write happens whether or not the line hits.
          st_wr_en   = hit;
          mem_wr_d   = 1'b1;
          mem_bval_d = bval_q;
          state_d    = ST_MEM_WR;
        end
      end
      ST_MEM_RD: begin
        if (mem_ack) begin
          st_wr_en   = 1'b1;
          st_wr_data = mem_rdata;
          st_wr_bval = BVAL_ALL;
          rdata_d    = mem_rdata;
          mem_rd_d   = 1'b0;
          ack_d      = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_MEM_WR: begin
        if (mem_ack) begin
          mem_wr_d = 1'b0;
          ack_d    = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && strobe) overrun_d = 1'b1;
  end

  always_ff @(posedge cache_clk) begin
    if (cache_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      bval_q     <= '0;
      is_wr_q    <= 1'b0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_bval_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      bval_q     <= bval_d;
      is_wr_q    <= is_wr_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      mem_bval_q <= mem_bval_d;
      overrun_q  <= overrun_d;
    end
  end

  assign cache_ack   = ack_q;
  assign cache_rdata = rdata_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_bval    = mem_bval_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign req_overrun = overrun_q;

endmodule

// File: tb/tb_cache_cpu_responder.sv
// Scoreboard bench for cache_cpu_responder: a reference cache/memory model
// predicts each transaction's data and hit/miss timing against a latency-3 memory.
module tb_cache_cpu_responder;

  localparam int MEM_LAT = 3;

  logic        cache_clk = 1'b0;
  logic        cache_rst = 1'b0;
  logic [15:0] cache_addr = '0;
  logic [31:0] cache_wdata = '0;
  logic [3:0]  cache_bval = '0;
  logic        cache_rd = 1'b0;
  logic        cache_wr = 1'b0;
  logic        cache_ack;
  logic [31:0] cache_rdata;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bval;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        req_overrun;

  typedef struct {
    logic        is_rd;
    logic        hit;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        acked;
    int          ack_k;
    int          mem_k;
    int          mem_ack_k;
    int          n_acks;
    logic [31:0] rdata;
    logic        mwr;
    logic [15:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mbval;
  } obs_t;

  exp_t        exp_q[$];
  logic [31:0] tb_mem [0:65535];
  logic [63:0] tb_valid;
  logic [9:0]  tb_tag [64];
  logic        mem_hold = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  cache_cpu_responder dut (
    .cache_clk   (cache_clk),
    .cache_rst   (cache_rst),
    .cache_addr  (cache_addr),
    .cache_wdata (cache_wdata),
    .cache_bval  (cache_bval),
    .cache_rd    (cache_rd),
    .cache_wr    (cache_wr),
    .cache_ack   (cache_ack),
    .cache_rdata (cache_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_bval    (mem_bval),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .req_overrun (req_overrun)
  );

  always #5 cache_clk = ~cache_clk;

  // Memory responder: acks a held request after MEM_LAT cycles; data is junk otherwise.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge cache_clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if ((mem_rd || mem_wr) && !mem_hold) begin
        cnt++;
        if (cnt >= MEM_LAT) begin
          mem_ack   = 1'b1;
          mem_rdata = tb_mem[mem_addr];
          cnt       = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  function automatic logic [31:0] merge_model(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    return {be[3] ? new_w[31:24] : old_w[31:24],
            be[2] ? new_w[23:16] : old_w[23:16],
            be[1] ? new_w[15:8]  : old_w[15:8],
            be[0] ? new_w[7:0]   : old_w[7:0]};
  endfunction

  function automatic logic model_hit(input logic [15:0] a);
    return tb_valid[a[5:0]] && (tb_tag[a[5:0]] == a[15:6]);
  endfunction

  task automatic do_reset();
    @(negedge cache_clk);
    cache_rst = 1'b1;
    cache_rd  = 1'b0;
    cache_wr  = 1'b0;
    @(negedge cache_clk);
    cache_rst = 1'b0;
    tb_valid  = '0;
  endtask

  // Drives one strobe, pushes the model's prediction, and records what the DUT did.
  task automatic issue(input logic wr, input logic rd, input logic [15:0] addr,
                       input logic [31:0] wdata, input logic [3:0] bval,
                       input int extra_k, output obs_t o);
    exp_t e;
    e.is_rd = !wr;
    e.hit   = model_hit(addr);
    e.rdata = tb_mem[addr];
    if (wr) begin
      tb_mem[addr] = merge_model(tb_mem[addr], wdata, bval);
    end else if (!e.hit) begin
      tb_valid[addr[5:0]] = 1'b1;
      tb_tag[addr[5:0]]   = addr[15:6];
    end
    exp_q.push_back(e);

    @(negedge cache_clk);
    cache_addr  = addr;
    cache_wdata = wdata;
    cache_bval  = bval;
    cache_rd    = rd;
    cache_wr    = wr;
    o = '{acked: 1'b0, ack_k: 0, mem_k: 0, mem_ack_k: 0, n_acks: 0,
          rdata: '0, mwr: 1'b0, maddr: '0, mwdata: '0, mbval: '0};
    for (int k = 1; k <= 60; k++) begin
      @(negedge cache_clk);
      cache_rd = (k == extra_k);
      cache_wr = 1'b0;
      if ((mem_rd || mem_wr) && o.mem_k == 0) begin
        o.mem_k  = k;
        o.mwr    = mem_wr;
        o.maddr  = mem_addr;
        o.mwdata = mem_wdata;
        o.mbval  = mem_bval;
      end
      if (mem_ack && o.mem_ack_k == 0) o.mem_ack_k = k;
      if (cache_ack) begin
        o.n_acks++;
        if (!o.acked) begin
          o.acked = 1'b1;
          o.ack_k = k;
          o.rdata = cache_rdata;
        end
      end
      if (o.acked && k >= o.ack_k + 3) break;
    end
    cache_rd = 1'b0;
  endtask

  task automatic test_reset();
    cache_rst = 1'b1;
    @(negedge cache_clk);
    @(negedge cache_clk);
    n_vec++; if (cache_ack !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ack: got %b, expected 0", cache_ack); end
    n_vec++; if (cache_rdata !== 32'h0) begin n_err++; $display("[TB] FAIL reset_rdata: got %h, expected 0", cache_rdata); end
    n_vec++; if ({mem_rd, mem_wr} !== 2'b00) begin n_err++; $display("[TB] FAIL reset_mem_req: got %b, expected 00", {mem_rd, mem_wr}); end
    n_vec++; if ({mem_addr, mem_wdata, mem_bval} !== 52'h0) begin n_err++; $display("[TB] FAIL reset_mem_bus: got %h, expected 0", {mem_addr, mem_wdata, mem_bval}); end
    n_vec++; if (req_overrun !== 1'b0) begin n_err++; $display("[TB] FAIL reset_overrun: got %b, expected 0", req_overrun); end
    cache_rst = 1'b0;
    tb_valid  = '0;
  endtask

  task automatic test_read_miss_hit();
    obs_t o;
    exp_t e;
    issue(1'b0, 1'b1, 16'h0041, 32'h0, 4'h0, 0, o);
    e = exp_q.pop_front();
    n_vec++; if (o.acked !== 1'b1) begin n_err++; $display("[TB] FAIL miss_acked: got %b, expected 1", o.acked); end
    n_vec++; if (o.mem_k != (e.hit ? 0 : 2)) begin n_err++; $display("[TB] FAIL miss_mem_rd_cycle: got %0d, expected %0d", o.mem_k, e.hit ? 0 : 2); end
    n_vec++; if (o.mwr !== 1'b0 || o.mbval !== 4'hF || o.maddr !== 16'h0041) begin n_err++; $display("[TB] FAIL miss_mem_req: got wr=%b bval=%h addr=%h, expected wr=0 bval=f addr=0041", o.mwr, o.mbval, o.maddr); end
    n_vec++; if (o.ack_k != o.mem_ack_k + 1) begin n_err++; $display("[TB] FAIL miss_ack_cycle: got %0d, expected %0d", o.ack_k, o.mem_ack_k + 1); end
    n_vec++; if (o.rdata !== e.rdata) begin n_err++; $display("[TB] FAIL miss_rdata: got %h, expected %h", o.rdata, e.rdata); end
    n_vec++; if (o.n_acks != 1) begin n_err++; $display("[TB] FAIL miss_ack_count: got %0d, expected 1", o.n_acks); end

    issue(1'b0, 1'b1, 16'h0041, 32'h0, 4'h0, 0, o);
    e = exp_q.pop_front();
    n_vec++; if (o.ack_k != (e.hit ? 2 : o.mem_ack_k + 1)) begin n_err++; $display("[TB] FAIL hit_ack_cycle: got %0d, expected %0d", o.ack_k, e.hit ? 2 : o.mem_ack_k + 1); end
    n_vec++; if (o.mem_k != (e.hit ? 0 : 2)) begin n_err++; $display("[TB] FAIL hit_no_mem: got %0d, expected %0d", o.mem_k, e.hit ? 0 : 2); end
    n_vec++; if (o.rdata !== e.rdata) begin n_err++; $display("[TB] FAIL hit_rdata: got %h, expected %h", o.rdata, e.rdata); end
  endtask

  task automatic test_write_merge();
    obs_t o;
    exp_t e;
    issue(1'b1, 1'b0, 16'h0041, 32'h00001234, 4'b0011, 0, o);
    e = exp_q.pop_front();
    n_vec++; if (o.acked !== 1'b1 || o.mem_k != 2 || o.mwr !== 1'b1) begin n_err++; $display("[TB] FAIL wr_mem_wr: got acked=%b mem_k=%0d wr=%b, expected 1 2 1", o.acked, o.mem_k, o.mwr); end
    n_vec++; if (o.mbval !== 4'b0011 || o.mwdata !== 32'h00001234) begin n_err++; $display("[TB] FAIL wr_mem_bus: got bval=%h data=%h, expected 3 00001234", o.mbval, o.mwdata); end
    n_vec++; if (o.ack_k != o.mem_ack_k + 1) begin n_err++; $display("[TB] FAIL wr_ack_cycle: got %0d, expected %0d", o.ack_k, o.mem_ack_k + 1); end
    n_vec++; if (o.rdata !== 32'hDEADBEEF) begin n_err++; $display("[TB] FAIL wr_keeps_rdata: got %h, expected deadbeef", o.rdata); end

    issue(1'b0, 1'b1, 16'h0041, 32'h0, 4'h0, 0, o);
    e = exp_q.pop_front();
    n_vec++; if (o.rdata !== e.rdata || o.mem_k != 0) begin n_err++; $display("[TB] FAIL merged_hit: got %h mem_k=%0d, expected %h mem_k=0", o.rdata, o.mem_k, e.rdata); end

    // Zero byte enables: still a memory write cycle, line content untouched.
    issue(1'b1, 1'b0, 16'h0041, 32'hFFFFFFFF, 4'b0000, 0, o);
    e = exp_q.pop_front();
    n_vec++; if (o.acked !== 1'b1 || o.mwr !== 1'b1 || o.mbval !== 4'h0) begin n_err++; $display("[TB] FAIL wr_bval0: got acked=%b wr=%b bval=%h, expected 1 1 0", o.acked, o.mwr, o.mbval); end
    issue(1'b0, 1'b1, 16'h0041, 32'h0, 4'h0, 0, o);
    e = exp_q.pop_front();
    n_vec++; if (o.rdata !== e.rdata || o.ack_k != 2) begin n_err++; $display("[TB] FAIL bval0_line: got %h ack_k=%0d, expected %h ack_k=2", o.rdata, o.ack_k, e.rdata); end
  endtask

  task automatic test_write_miss();
    obs_t o;
    exp_t e;
    issue(1'b1, 1'b0, 16'h0082, 32'h11223344, 4'hF, 0, o);
    e = exp_q.pop_front();
    n_vec++; if (o.acked !== 1'b1 || o.mwr !== 1'b1 || o.maddr !== 16'h0082) begin n_err++; $display("[TB] FAIL wmiss_req: got acked=%b wr=%b addr=%h, expected 1 1 0082", o.acked, o.mwr, o.maddr); end
    issue(1'b0, 1'b1, 16'h0082, 32'h0, 4'h0, 0, o);
    e = exp_q.pop_front();
    n_vec++; if (o.mem_k != (e.hit ? 0 : 2) || o.rdata !== e.rdata) begin n_err++; $display("[TB] FAIL wmiss_no_alloc: got mem_k=%0d %h, expected mem_k=%0d %h", o.mem_k, o.rdata, e.hit ? 0 : 2, e.rdata); end
  endtask

  task automatic test_conflict();
    obs_t o;
    exp_t e;
    logic [15:0] seq [3];
    seq = '{16'h0005, 16'h0045, 16'h0005};
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b1, seq[i], 32'h0, 4'h0, 0, o);
      e = exp_q.pop_front();
      n_vec++; if (o.mem_k != (e.hit ? 0 : 2) || o.rdata !== e.rdata) begin n_err++; $display("[TB] FAIL conflict_%0d: got mem_k=%0d %h, expected mem_k=%0d %h", i, o.mem_k, o.rdata, e.hit ? 0 : 2, e.rdata); end
    end
  endtask

  task automatic test_overrun();
    obs_t o;
    exp_t e;
    n_vec++; if (req_overrun !== 1'b0) begin n_err++; $display("[TB] FAIL ovr_clean: got %b, expected 0", req_overrun); end
    issue(1'b0, 1'b1, 16'h0123, 32'h0, 4'h0, 3, o);
    e = exp_q.pop_front();
    n_vec++; if (req_overrun !== 1'b1) begin n_err++; $display("[TB] FAIL ovr_busy_flag: got %b, expected 1", req_overrun); end
    n_vec++; if (o.n_acks != 1 || o.rdata !== e.rdata) begin n_err++; $display("[TB] FAIL ovr_single_ack: got acks=%0d %h, expected 1 %h", o.n_acks, o.rdata, e.rdata); end

    do_reset();
    n_vec++; if (req_overrun !== 1'b0) begin n_err++; $display("[TB] FAIL ovr_reset_clear: got %b, expected 0", req_overrun); end
    issue(1'b1, 1'b1, 16'h0200, 32'hCAFEF00D, 4'hF, 0, o);
    e = exp_q.pop_front();
    n_vec++; if (o.acked !== 1'b1 || o.mwr !== 1'b1 || o.mwdata !== 32'hCAFEF00D) begin n_err++; $display("[TB] FAIL ovr_rdwr_write: got acked=%b wr=%b data=%h, expected 1 1 cafef00d", o.acked, o.mwr, o.mwdata); end
    n_vec++; if (req_overrun !== 1'b1 || o.n_acks != 1) begin n_err++; $display("[TB] FAIL ovr_rdwr_flag: got %b acks=%0d, expected 1 acks=1", req_overrun, o.n_acks); end
  endtask

  task automatic test_reset_mid_miss();
    obs_t o;
    exp_t e;
    logic seen;
    int   n;
    issue(1'b0, 1'b1, 16'h0041, 32'h0, 4'h0, 0, o);
    e = exp_q.pop_front();
    issue(1'b0, 1'b1, 16'h0041, 32'h0, 4'h0, 0, o);
    e = exp_q.pop_front();
    n_vec++; if (o.ack_k != 2 || o.rdata !== e.rdata) begin n_err++; $display("[TB] FAIL rst_prehit: got ack_k=%0d %h, expected 2 %h", o.ack_k, o.rdata, e.rdata); end

    mem_hold = 1'b1;
    @(negedge cache_clk);
    cache_addr = 16'h0010;
    cache_rd   = 1'b1;
    @(negedge cache_clk);
    cache_rd = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge cache_clk);
      if (mem_rd) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b1) begin n_err++; $display("[TB] FAIL rst_mem_rd_up: got %b, expected 1", seen); end
    cache_rst = 1'b1;
    @(negedge cache_clk);
    n_vec++; if (mem_rd !== 1'b0 || cache_ack !== 1'b0) begin n_err++; $display("[TB] FAIL rst_drop: got mem_rd=%b ack=%b, expected 0 0", mem_rd, cache_ack); end
    cache_rst = 1'b0;
    mem_hold  = 1'b0;
    tb_valid  = '0;
    n = 0;
    repeat (8) begin
      @(negedge cache_clk);
      if (cache_ack) n++;
    end
    n_vec++; if (n != 0) begin n_err++; $display("[TB] FAIL rst_no_ack: got %0d, expected 0", n); end

    issue(1'b0, 1'b1, 16'h0041, 32'h0, 4'h0, 0, o);
    e = exp_q.pop_front();
    n_vec++; if (o.mem_k != (e.hit ? 0 : 2) || o.rdata !== e.rdata) begin n_err++; $display("[TB] FAIL rst_invalidated: got mem_k=%0d %h, expected mem_k=%0d %h", o.mem_k, o.rdata, e.hit ? 0 : 2, e.rdata); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) tb_mem[i] = 32'(i) ^ 32'h5A5A0000;
    tb_mem[16'h0041] = 32'hDEADBEEF;
    tb_valid = '0;
    for (int i = 0; i < 64; i++) tb_tag[i] = '0;

    test_reset();
    test_read_miss_hit();
    test_write_merge();
    test_write_miss();
    test_conflict();
    test_overrun();
    test_reset_mid_miss();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
